// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit -- multiply/divide unit with architectural HI/LO registers.
//
// An accepted multiply or divide computes its full result on the accepting
// edge and parks it in a pending register. A down-counter then models the
// unit's latency. When the counter steps from 1 to 0, the pending value is
// written to HI/LO. mthi/mtlo bypass the counter and write on the accepting
// edge.
//
// Optional feature: define MDU_MADD_EN to enable op 7 (madd), a signed
// multiply-accumulate into {hi,lo}. Without the macro, op 7 behaves as op 0
// and the accumulate adder is not built.
//
// Handshake: start is sampled on every rising edge. An op is accepted only
// when busy is low. A start while busy is dropped silently and there is no
// back-pressure or retry. busy is high for exactly the latency of the
// accepted op, beginning the cycle after acceptance.
//
// Ports
//   clk    in   clock; all state changes on its rising edge
//   reset  in   asynchronous, active-low reset
//   start  in   issue request for op this cycle
//   op     in   3-bit opcode:
//                 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                 5 mthi, 6 mtlo, 7 madd
//   src_a  in   WIDTH; rs: dividend / multiplicand / mthi-mtlo data
//   src_b  in   WIDTH; rt: divisor / multiplier
//   busy   out  multiply or divide in progress
//   hi     out  WIDTH; architectural HI
//   lo     out  WIDTH; architectural LO
// -----------------------------------------------------------------------------
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW = 2 * WIDTH;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [PW-1:0]    pend_q, pend_d;       // {hi,lo} result awaiting commit
  logic             pend_wr_q, pend_wr_d; // 0 for divide-by-zero: commit is a no-op
`ifdef MDU_MADD_EN
  logic             pend_acc_q, pend_acc_d; // pending value is an addend, not a result
`endif

  // ---------------------------------------------------------------------------
  // Datapath: results computed from the operands present at acceptance
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    prod_s;
  logic [PW-1:0]    prod_u;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b, safe_b;
  logic [WIDTH-1:0] q_mag, r_mag;
  logic [WIDTH-1:0] quot, rem;
  logic             div_zero;

  always_comb begin
    // Sign-extending both factors to 2*WIDTH makes the low 2*WIDTH bits
    // of the plain product equal to the signed product.
    prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
    prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

    // Signed divide runs on magnitudes, then the signs are restored.
    // For most-negative / -1, the magnitude quotient 2^(WIDTH-1) reads back as
    // most-negative with a zero remainder, so no special case is needed.
    a_neg    = (op == OP_DIV) && src_a[WIDTH-1];
    b_neg    = (op == OP_DIV) && src_b[WIDTH-1];
    mag_a    = a_neg ? -src_a : src_a;
    mag_b    = b_neg ? -src_b : src_b;
    div_zero = (src_b == '0);
    // Keep the divider away from a zero divisor. That result is discarded.
    safe_b   = div_zero ? WIDTH'(1) : mag_b;
    q_mag    = mag_a / safe_b;
    r_mag    = mag_a % safe_b;
    quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem      = a_neg ? -r_mag : r_mag;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
`ifdef MDU_MADD_EN
    pend_acc_d = pend_acc_q;
`endif

    if (cnt_q != 4'd0) begin
      // In flight: any start this cycle is ignored.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && pend_wr_q) begin
`ifdef MDU_MADD_EN
        // The accumulate reads {hi,lo} at commit time.
        if (pend_acc_q) {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
        else            {hi_d, lo_d} = pend_q;
`else
        {hi_d, lo_d} = pend_q;
`endif
      end
    end else if (start) begin
      case (op)
        OP_MULT: begin
          cnt_d     = MULT_LOAD;
          pend_d    = prod_s;
          pend_wr_d = 1'b1;
`ifdef MDU_MADD_EN
          pend_acc_d = 1'b0;
`endif
        end
        OP_MULTU: begin
          cnt_d     = MULT_LOAD;
          pend_d    = prod_u;
          pend_wr_d = 1'b1;
`ifdef MDU_MADD_EN
          pend_acc_d = 1'b0;
`endif
        end
        OP_DIV, OP_DIVU: begin
          cnt_d     = DIV_LOAD;
          pend_d    = {rem, quot};
          pend_wr_d = !div_zero;
`ifdef MDU_MADD_EN
          pend_acc_d = 1'b0;
`endif
        end
        OP_MTHI: hi_d = src_a;
        OP_MTLO: lo_d = src_a;
`ifdef MDU_MADD_EN
        OP_MADD: begin
          cnt_d      = MULT_LOAD;
          pend_d     = prod_s;
          pend_wr_d  = 1'b1;
          pend_acc_d = 1'b1;
        end
`endif
        // OP_NONE, and OP_MADD when the feature is compiled out.
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= 4'd0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
`ifdef MDU_MADD_EN
      pend_acc_q <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
`ifdef MDU_MADD_EN
      pend_acc_q <= pend_acc_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy = (cnt_q != 4'd0);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // OP_NONE is named for readability. The case default covers it.
  logic unused_op_none;
  assign unused_op_none = (OP_NONE == 3'd0);

endmodule

// File: tb/tb_mdu_unit.sv
module tb_mdu_unit;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [2:0] NONE  = 3'd0;
  localparam logic [2:0] MULT  = 3'd1;
  localparam logic [2:0] MULTU = 3'd2;
  localparam logic [2:0] DIV   = 3'd3;
  localparam logic [2:0] DIVU  = 3'd4;
  localparam logic [2:0] MTHI  = 3'd5;
  localparam logic [2:0] MTLO  = 3'd6;
  localparam logic [2:0] MADD  = 3'd7;

  // ---------------- clock / reset ----------------
  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op    = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_q[$];  // {hi,lo} expected when a busy op completes
  int             len_q[$];  // expected busy length for that op
  logic [2*W-1:0] imm_q[$];  // {hi,lo} expected right after a no-busy op
  bit             imm_flag = 1'b0;

  // Reference architectural state
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  bit             prev_busy = 1'b0;
  int             busy_run  = 0;
  logic [2*W-1:0] mon_e;
  int             mon_l;

  always @(negedge clk) begin
    if (!reset) begin
      prev_busy = 1'b0;
      busy_run  = 0;
    end else begin
      if (busy === 1'b1) busy_run++;
      if (prev_busy && busy === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion hi=%h lo=%h", hi, lo);
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = len_q.pop_front();
          chk("commit_hilo", {hi, lo}, mon_e);
          chk("busy_len", 64'(busy_run), 64'(mon_l));
        end
        busy_run = 0;
      end
      if (imm_flag) begin
        if (imm_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL imm_queue_empty hi=%h lo=%h", hi, lo);
        end else begin
          mon_e = imm_q.pop_front();
          chk("imm_hilo", {hi, lo}, mon_e);
          chk("imm_busy", 64'(busy), 64'd0);
        end
      end
      prev_busy = (busy === 1'b1);
    end
  end

  // ---------------- driver ----------------
  // Updates the reference model, pushes the expectation, and drives the op.
  // If inject is set, a second start is attempted while the first op is busy.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit inject, input logic [2:0] inj_op, input logic [W-1:0] inj_a);
    longint         p, sa, sb, q, r;
    logic [63:0]    pu;
    int             len;
    len = 0;
    case (o)
      MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {m_hi, m_lo} = 64'(p);
        len = MC;
      end
      MULTU: begin
        pu = 64'(a) * 64'(b);
        {m_hi, m_lo} = pu;
        len = MC;
      end
      DIV: begin
        if (b != 0) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
        len = DC;
      end
      DIVU: begin
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
        len = DC;
      end
      MTHI: m_hi = a;
      MTLO: m_lo = a;
`ifdef MDU_MADD_EN
      MADD: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {m_hi, m_lo} = {m_hi, m_lo} + 64'(p);
        len = MC;
      end
`endif
      default: ;
    endcase

    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #2;
    start = 1'b0; imm_flag = 1'b0;
    src_a = $urandom; src_b = $urandom;  // must not disturb the result
    if (len == 0) begin
      imm_q.push_back({m_hi, m_lo});
      imm_flag = 1'b1;
    end else begin
      exp_q.push_back({m_hi, m_lo});
      len_q.push_back(len);
      if (inject) begin
        start = 1'b1; op = inj_op; src_a = inj_a; src_b = $urandom;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (len - 1) @(posedge clk);
      end else begin
        repeat (len) @(posedge clk);
      end
      #2;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    @(posedge clk); #2;
    reset = 1'b1;

    // Signed mult, issued immediately after reset release
    do_op(MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, NONE, '0);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    // Signed div with negative dividend
    do_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, NONE, '0);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // divu by zero leaves hi/lo alone
    do_op(DIVU, 32'd7, 32'd0, 1'b0, NONE, '0);
    chk("divu_zero", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // mtlo while busy is dropped
    do_op(MULT, 32'd3, 32'd4, 1'b1, MTLO, 32'h1234);
    chk("ignore_busy_lo", 64'(lo), 64'd12);

    // Back-to-back mthi then mtlo
    do_op(MTHI, 32'hDEAD_BEEF, '0, 1'b0, NONE, '0);
    do_op(MTLO, 32'h0000_0055, '0, 1'b0, NONE, '0);
    do_op(NONE, 32'h1111_1111, 32'h2222_2222, 1'b0, NONE, '0);
    chk("mthi_mtlo", {hi, lo}, 64'hDEAD_BEEF_0000_0055);

    // Most-negative / -1
    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, NONE, '0);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

    // Largest unsigned product
    do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, NONE, '0);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // madd carry into hi (or no effect when compiled out)
    do_op(MTHI, 32'h0, '0, 1'b0, NONE, '0);
    do_op(MTLO, 32'hFFFF_FFFF, '0, 1'b0, NONE, '0);
    do_op(MADD, 32'd1, 32'd1, 1'b0, NONE, '0);
    do_op(NONE, '0, '0, 1'b0, NONE, '0);
`ifdef MDU_MADD_EN
    chk("madd", {hi, lo}, 64'h0000_0001_0000_0000);
`else
    chk("madd_off", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    // Randomized ops, with random starts injected while busy
    for (int i = 0; i < 60; i++) begin
      logic [2:0] o;
      logic [W-1:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op(o, a, b, 1'($urandom_range(0, 1)), 3'($urandom_range(1, 7)), $urandom);
    end
    do_op(NONE, '0, '0, 1'b0, NONE, '0);

    // Reset in cycle 3 of a divide aborts it
    do_op(MTHI, 32'hAAAA_0001, '0, 1'b0, NONE, '0);
    do_op(MTLO, 32'h5555_0002, '0, 1'b0, NONE, '0);
    start = 1'b1; op = DIV; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #2;
    start = 1'b0; imm_flag = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (DC + 3) @(posedge clk);
    #2;
    chk("post_abort_busy", 64'(busy), 64'd0);
    chk("post_abort_hilo", {hi, lo}, 64'd0);

    // Every expectation must have been consumed
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("imm_q_drained", 64'(imm_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hang
  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 The block SHALL have parameter MULT_CYCLES, default 5, giving the busy duration of multiply ops (range 1..15).
REQ-003 The block SHALL have parameter DIV_CYCLES, default 10, giving the busy duration of divide ops (range 1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-006 The block SHALL have port start, input, 1 bit: requests issue of op this cycle.
REQ-007 The block SHALL have port op, input, 3 bits: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd.
REQ-008 The block SHALL have port src_a, input, WIDTH bits: rs operand (dividend / multiplicand / mthi-mtlo data).
REQ-009 The block SHALL have port src_b, input, WIDTH bits: rt operand (divisor / multiplier).
REQ-010 The block SHALL have port busy, output, 1 bit: a multiply or divide is in progress.
REQ-011 The block SHALL have port hi, output, WIDTH bits: architectural HI register.
REQ-012 The block SHALL have port lo, output, WIDTH bits: architectural LO register.

Function
REQ-013 start SHALL be accepted only when busy=0; when busy=1, start SHALL be ignored with no state change.
REQ-014 An accepted mult/multu/madd SHALL load a cycle counter with MULT_CYCLES, and div/divu with DIV_CYCLES.
REQ-015 busy SHALL be (counter != 0), i.e. high exactly N cycles starting the cycle after acceptance.
REQ-016 The result SHALL be computed from the operands captured at acceptance and held in internal pending registers.
REQ-017 Changes to src_a/src_b after acceptance SHALL NOT affect the result.
REQ-018 On the edge where the counter goes 1->0, pending results SHALL be written to hi/lo, so they are visible in the same cycle busy falls.
REQ-019 mult SHALL produce the signed 2*WIDTH product {hi,lo}; multu SHALL produce the unsigned product.
REQ-020 div SHALL write the signed quotient to lo (truncated toward zero) and the remainder to hi (sign of dividend).
REQ-021 divu SHALL write the unsigned quotient to lo and the remainder to hi.
REQ-022 A divisor of 0 SHALL leave hi/lo unchanged while still holding busy for DIV_CYCLES.
REQ-023 Signed div of most-negative by -1 SHALL give lo = most-negative, hi = 0.
REQ-024 mthi/mtlo SHALL write src_a to hi/lo on the accepting edge, with no busy cycle.
REQ-025 op 0 with start=1 SHALL have no effect.
REQ-026 hi and lo SHALL hold their values between writes.

Reset
REQ-027 On reset=0, regardless of clock, counter, busy, hi, lo and pending registers SHALL clear to 0, aborting any in-flight op with no hi/lo update.
REQ-028 The first start SHALL be accepted on the first rising edge after reset returns to 1.

Configuration
REQ-029 With macro MDU_MADD_EN defined, op 7 (madd) SHALL add the signed src_a*src_b product to {hi,lo} (2*WIDTH wrap-around) with MULT_CYCLES latency.
REQ-030 The madd accumulation SHALL use the {hi,lo} value at commit time.
REQ-031 Without MDU_MADD_EN, op 7 SHALL be treated as op 0, and no accumulate adder SHALL be synthesised.

Verification
REQ-032 WIDTH=32, MULT_CYCLES=5: start, mult, a=0xFFFFFFFE, b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 div a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 -> hi/lo unchanged, busy 10 cycles.
REQ-034 start mult while busy (second op mtlo 0x1234) -> ignored; final lo equals the first op's result.
REQ-035 mthi 0xDEADBEEF -> hi=0xDEADBEEF next cycle, busy stays 0; a back-to-back mtlo in the following cycle is also accepted.
REQ-036 Assert reset=0 in cycle 3 of a div -> busy, hi, lo read 0 immediately; no later update.
REQ-037 MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, madd a=1, b=1 -> hi=1, lo=0; undefined -> hi/lo unchanged.
